// File: rtl/regfile_pkg.sv
// Shared definitions for the banked register file: clear-FSM state encoding
// and default sizing constants.
// Latency: n/a (types and constants only). Backpressure: n/a.
package regfile_pkg;

    localparam int DEF_DATA_W   = 8;
    localparam int DEF_NUM_REGS = 4;
    localparam int DEF_NUM_RD   = 3;

    // IDLE accepts writes and clear requests; CLEAR walks the array zeroing it.
    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

endpackage

// File: rtl/regfile_clear_fsm.sv
// Sequencer that zeroes the register array one entry per cycle on request.
// Latency: CLEAR entered one edge after request, lasts NUM_REGS cycles, done pulses one cycle after.
// Backpressure: requests during CLEAR are ignored; o_idle gates write acceptance in the parent.
//
// Ports:
//   clk, reset        - core clock, asynchronous active-high reset
//   i_clear_req       - start a clear sequence (honoured only in IDLE)
//   o_idle            - FSM is in IDLE (writes may be accepted)
//   o_clr_en, o_clr_idx - zero register o_clr_idx at the coming edge
//   o_clear_busy      - high while in CLEAR
//   o_clear_done      - registered one-cycle pulse on the first IDLE cycle after CLEAR
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    localparam int ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_clear_req,
    output logic              o_idle,
    output logic              o_clr_en,
    output logic [ADDR_W-1:0] o_clr_idx,
    output logic              o_clear_busy,
    output logic              o_clear_done
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    clr_state_t        r_state;
    logic [ADDR_W-1:0] r_clr_idx;
    logic              r_clear_done;

    clr_state_t        w_state_nxt;
    logic [ADDR_W-1:0] w_clr_idx_nxt;
    logic              w_clear_done_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_clr_idx    <= '0;
            r_clear_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_clr_idx    <= w_clr_idx_nxt;
            r_clear_done <= w_clear_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_clr_idx_nxt    = r_clr_idx;
        w_clear_done_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_clear_req) begin
                    w_state_nxt   = CLEAR;
                    w_clr_idx_nxt = '0;
                end
            end
            CLEAR: begin
                // The edge that zeroes the last entry also returns to IDLE,
                // so the sequence is exactly NUM_REGS cycles long.
                w_clr_idx_nxt = r_clr_idx + 1'b1;
                if (r_clr_idx == LAST_IDX) begin
                    w_state_nxt      = IDLE;
                    w_clr_idx_nxt    = '0;
                    w_clear_done_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt   = IDLE;
                w_clr_idx_nxt = '0;
            end
        endcase
    end

    assign o_idle       = (r_state == IDLE);
    assign o_clr_en     = (r_state == CLEAR);
    assign o_clr_idx    = r_clr_idx;
    assign o_clear_busy = (r_state == CLEAR);
    assign o_clear_done = r_clear_done;

endmodule

// File: rtl/regfile_banked.sv
// Multi-read-port register file with a single write port and a sequential clear.
// Latency: reads combinational (zero cycles); writes land at the accepting edge.
// Backpressure: writes during a clear are dropped and flagged by a registered write_drop pulse.
//
// Ports:
//   clk, reset            - clock, asynchronous active-high reset
//   read_reg / read_data  - NUM_RD read address / data pairs
//   write_reg, write_data, write_en - single write port
//   clear_req             - start a clear of all registers
//   clear_busy            - high while the clear runs
//   clear_done            - one-cycle pulse when the clear finishes
//   write_drop            - one-cycle registered pulse after a rejected write
// Build option: define REGFILE_BYPASS_EN to forward an accepted write's data
// to any read port addressing the same register in the same cycle.
module regfile_banked
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int NUM_RD   = DEF_NUM_RD,
    localparam int ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_RD-1:0][ADDR_W-1:0]  read_reg,
    output logic [NUM_RD-1:0][DATA_W-1:0]  read_data,
    input  logic [ADDR_W-1:0]              write_reg,
    input  logic [DATA_W-1:0]              write_data,
    input  logic                           write_en,
    input  logic                           clear_req,
    output logic                           clear_busy,
    output logic                           clear_done,
    output logic                           write_drop
);

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic              r_write_drop;

    logic              w_idle;
    logic              w_clr_en;
    logic [ADDR_W-1:0] w_clr_idx;
    logic              w_wr_acc;

    regfile_clear_fsm #(
        .NUM_REGS (NUM_REGS)
    ) u_clear_fsm (
        .clk          (clk),
        .reset        (reset),
        .i_clear_req  (clear_req),
        .o_idle       (w_idle),
        .o_clr_en     (w_clr_en),
        .o_clr_idx    (w_clr_idx),
        .o_clear_busy (clear_busy),
        .o_clear_done (clear_done)
    );

    // A write is only taken in IDLE; a simultaneous clear_req still starts the
    // clear on the same edge, and the clear later zeroes the written entry.
    assign w_wr_acc = write_en & w_idle;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                r_regs[k] <= '0;
            end
        end else if (w_clr_en) begin
            r_regs[w_clr_idx] <= '0;
        end else if (w_wr_acc) begin
            r_regs[write_reg] <= write_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_write_drop <= 1'b0;
        end else begin
            r_write_drop <= write_en & ~w_idle;
        end
    end

    assign write_drop = r_write_drop;

    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
`ifdef REGFILE_BYPASS_EN
        // Only accepted writes forward; a dropped write never reaches a reader.
        assign read_data[gi] = (w_wr_acc && (write_reg == read_reg[gi]))
                               ? write_data : r_regs[read_reg[gi]];
`else
        assign read_data[gi] = r_regs[read_reg[gi]];
`endif
    end

endmodule

// File: tb/tb_regfile_banked.sv
// Directed bench for regfile_banked: reset, reads, writes, bypass, clear
// sequencing, dropped writes during clear, and reset aborting a clear.
module tb_regfile_banked;

    logic             clk;
    logic             reset;
    logic [2:0][1:0]  read_reg;
    logic [2:0][7:0]  read_data;
    logic [1:0]       write_reg;
    logic [7:0]       write_data;
    logic             write_en;
    logic             clear_req;
    logic             clear_busy;
    logic             clear_done;
    logic             write_drop;

    int n_vec  = 0;
    int n_miss = 0;

    regfile_banked dut (
        .clk        (clk),
        .reset      (reset),
        .read_reg   (read_reg),
        .read_data  (read_data),
        .write_reg  (write_reg),
        .write_data (write_data),
        .write_en   (write_en),
        .clear_req  (clear_req),
        .clear_busy (clear_busy),
        .clear_done (clear_done),
        .write_drop (write_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        write_en   = 1'b1;
        write_reg  = a;
        write_data = d;
        tick();
        write_en   = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] a, input logic [7:0] exp);
        read_reg[0] = a;
        #1;
        chk(tag, read_data[0], exp);
    endtask

    task automatic chk_all(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                           input logic [7:0] e2, input logic [7:0] e3);
        read_reg[0] = 2'd0;
        read_reg[1] = 2'd1;
        read_reg[2] = 2'd2;
        #1;
        chk({tag, "_r0"}, read_data[0], e0);
        chk({tag, "_r1"}, read_data[1], e1);
        chk({tag, "_r2"}, read_data[2], e2);
        rd_chk({tag, "_r3"}, 2'd3, e3);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        read_reg   = '0;
        write_reg  = '0;
        write_data = '0;
        write_en   = 1'b0;
        clear_req  = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        tick();
        chk_all("rst", 8'h00, 8'h00, 8'h00, 8'h00);
        chk("rst_busy", clear_busy, 0);
        chk("rst_done", clear_done, 0);
        chk("rst_drop", write_drop, 0);

        // Write, then read the same register on two ports
        wr(2'd2, 8'hA5);
        read_reg[2] = 2'd2;
        read_reg[1] = 2'd2;
        read_reg[0] = 2'd1;
        #1;
        chk("wr_p2", read_data[2], 8'hA5);
        chk("wr_p1", read_data[1], 8'hA5);
        chk("wr_p0", read_data[0], 8'h00);

        // Same-cycle write and read of reg 1
        write_en    = 1'b1;
        write_reg   = 2'd1;
        write_data  = 8'h3C;
        read_reg[0] = 2'd1;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("bypass", read_data[0], 8'h3C);
`else
        chk("bypass", read_data[0], 8'h00);
`endif
        tick();
        write_en = 1'b0;
        rd_chk("after_wr1", 2'd1, 8'h3C);

        // Full clear; clear_req held through CLEAR must not restart it
        wr(2'd0, 8'h11);
        wr(2'd1, 8'h22);
        wr(2'd2, 8'h33);
        wr(2'd3, 8'h44);
        clear_req = 1'b1;
        tick();                                  // E0: enter CLEAR
        chk("clr_busy0", clear_busy, 1);
        chk_all("clr_c0", 8'h11, 8'h22, 8'h33, 8'h44);
        tick();                                  // E1: reg0 zeroed
        chk("clr_busy1", clear_busy, 1);
        chk_all("clr_c1", 8'h00, 8'h22, 8'h33, 8'h44);
        tick();                                  // E2
        chk("clr_busy2", clear_busy, 1);
        chk("clr_done2", clear_done, 0);
        tick();                                  // E3
        chk("clr_busy3", clear_busy, 1);
        chk_all("clr_c3", 8'h00, 8'h00, 8'h00, 8'h44);
        clear_req = 1'b0;
        tick();                                  // E4: back to IDLE
        chk("clr_busy4", clear_busy, 0);
        chk("clr_done4", clear_done, 1);
        chk_all("clr_end", 8'h00, 8'h00, 8'h00, 8'h00);
        tick();
        chk("clr_done5", clear_done, 0);
        chk("clr_busy5", clear_busy, 0);

        // Write during second CLEAR cycle is dropped and never forwarded
        wr(2'd1, 8'h5A);
        clear_req = 1'b1;
        tick();                                  // E0
        clear_req = 1'b0;
        tick();                                  // E1: second CLEAR cycle
        chk("drop_pre", write_drop, 0);
        write_en    = 1'b1;
        write_reg   = 2'd0;
        write_data  = 8'h77;
        read_reg[0] = 2'd0;
        #1;
        chk("drop_nobyp", read_data[0], 8'h00);
        tick();                                  // E2
        write_en = 1'b0;
        chk("drop_pulse", write_drop, 1);
        rd_chk("drop_reg0", 2'd0, 8'h00);
        tick();                                  // E3
        chk("drop_clr", write_drop, 0);
        tick();                                  // E4
        chk("drop_done", clear_done, 1);
        rd_chk("drop_reg0b", 2'd0, 8'h00);
        tick();

        // Reset in mid-clear aborts with no done pulse
        wr(2'd0, 8'hA1);
        wr(2'd1, 8'hA2);
        wr(2'd2, 8'hA3);
        wr(2'd3, 8'hA4);
        clear_req = 1'b1;
        tick();                                  // E0
        clear_req = 1'b0;
        tick();                                  // E1
        tick();                                  // E2
        reset = 1'b1;
        #1;
        chk("abort_busy", clear_busy, 0);
        chk("abort_done", clear_done, 0);
        chk_all("abort", 8'h00, 8'h00, 8'h00, 8'h00);
        tick();
        tick();
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("abort_nodone", clear_done, 0);
            chk("abort_idle", clear_busy, 0);
        end

        // Write and clear_req together: write taken, then zeroed by the clear
        write_en   = 1'b1;
        write_reg  = 2'd3;
        write_data = 8'h99;
        clear_req  = 1'b1;
        tick();                                  // E0
        write_en  = 1'b0;
        clear_req = 1'b0;
        chk("both_busy", clear_busy, 1);
        chk("both_drop", write_drop, 0);
        rd_chk("both_wr", 2'd3, 8'h99);
        repeat (4) tick();
        chk("both_done", clear_done, 1);
        rd_chk("both_zero", 2'd3, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
